// File: rtl/serial_pkg.sv
// Shared definitions for the serial pattern transmitter and the sequence
// detectors that consume its bit stream.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } tx_state_e;

  localparam logic [3:0] PATTERN_1011 = 4'b1011;

endpackage : serial_pkg

// File: rtl/serial_pattern_tx.sv
// Parallel-to-serial transmitter: accepts WIDTH-bit words over valid/ready and
// shifts them out MSB-first, one bit per clk, with an optional idle gap.
module serial_pattern_tx
  import serial_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             x_o,
  output logic             bit_valid_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);
  localparam bit               HAS_GAP  = (GAP_CYCLES > 0);
  localparam logic [7:0]       GAP_LAST = HAS_GAP ? 8'(GAP_CYCLES - 1) : 8'd0;

  tx_state_e        state_q,     state_d;
  logic [WIDTH-1:0] shift_q,     shift_d;
  logic [CNT_W-1:0] bit_cnt_q,   bit_cnt_d;
  logic [7:0]       gap_cnt_q,   gap_cnt_d;
  logic             x_q,         x_d;
  logic             bit_valid_q, bit_valid_d;
  logic             done_q,      done_d;

  logic last_bit;
  logic accept;

  assign last_bit = (state_q == SHIFT) && (bit_cnt_q == BIT_LAST);

  // Without a gap, the last-bit cycle can already take the next word.
  assign ready_o = !rst && ((state_q == IDLE) || (last_bit && !HAS_GAP));
  assign accept  = valid_i && ready_o;

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    x_d         = 1'b0;
    bit_valid_d = 1'b0;
    done_d      = 1'b0;

    if (accept) begin
      // MSB goes straight to the output register; the rest waits in shift_q.
      state_d     = SHIFT;
      shift_d     = data_i << 1;
      bit_cnt_d   = '0;
      gap_cnt_d   = '0;
      x_d         = data_i[WIDTH-1];
      bit_valid_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end

        SHIFT: begin
          if (!last_bit) begin
            shift_d     = shift_q << 1;
            bit_cnt_d   = bit_cnt_q + 1'b1;
            x_d         = shift_q[WIDTH-1];
            bit_valid_d = 1'b1;
            done_d      = (bit_cnt_d == BIT_LAST);
          end else if (HAS_GAP) begin
            state_d   = GAP;
            bit_cnt_d = '0;
            gap_cnt_d = '0;
          end else begin
            state_d   = IDLE;
            bit_cnt_d = '0;
          end
        end

        GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            state_d   = IDLE;
            gap_cnt_d = '0;
          end else begin
            gap_cnt_d = gap_cnt_q + 8'd1;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before this edge.
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      x_q         <= 1'b0;
      bit_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      x_q         <= x_d;
      bit_valid_q <= bit_valid_d;
      done_q      <= done_d;
    end
  end

  assign x_o         = x_q;
  assign bit_valid_o = bit_valid_q;
  assign done_o      = done_q;
  assign busy_o      = (state_q != IDLE);

endmodule : serial_pattern_tx

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx: one gapless instance, one with a
// two-cycle gap, plus a small 1011 detector model on the gapless stream.
module tb_serial_pattern_tx;
  import serial_pkg::*;

  logic       clk;
  logic       rst;
  logic [3:0] data0, data2;
  logic       valid0, valid2;
  logic       ready0, x0, bv0, busy0, done0;
  logic       ready2, x2, bv2, busy2, done2;

  int n_vec;
  int n_err;
  int sel;

  serial_pattern_tx #(.WIDTH(4), .GAP_CYCLES(0)) u_tx0 (
    .clk        (clk),
    .rst        (rst),
    .data_i     (data0),
    .valid_i    (valid0),
    .ready_o    (ready0),
    .x_o        (x0),
    .bit_valid_o(bv0),
    .busy_o     (busy0),
    .done_o     (done0)
  );

  serial_pattern_tx #(.WIDTH(4), .GAP_CYCLES(2)) u_tx2 (
    .clk        (clk),
    .rst        (rst),
    .data_i     (data2),
    .valid_i    (valid2),
    .ready_o    (ready2),
    .x_o        (x2),
    .bit_valid_o(bv2),
    .busy_o     (busy2),
    .done_o     (done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream 1011 detector on the gapless stream.
  logic [2:0] hist;
  logic       det_y;
  always @(posedge clk) begin
    if (rst)      hist <= 3'b000;
    else if (bv0) hist <= {hist[1:0], x0};
  end
  assign det_y = bv0 && ({hist, x0} == PATTERN_1011);

  logic s_x, s_bv, s_done, s_ready, s_busy;
  assign s_x     = (sel == 0) ? x0     : x2;
  assign s_bv    = (sel == 0) ? bv0    : bv2;
  assign s_done  = (sel == 0) ? done0  : done2;
  assign s_ready = (sel == 0) ? ready0 : ready2;
  assign s_busy  = (sel == 0) ? busy0  : busy2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_idle(input string tag, input logic exp_ready, input logic exp_busy);
    check({tag, "_line"}, {s_x, s_bv, s_done}, 3'b000);
    check({tag, "_rdy"}, s_ready, exp_ready);
    check({tag, "_busy"}, s_busy, exp_busy);
  endtask

  // Called in the cycle after the accepting edge; returns in the last-bit cycle.
  task automatic expect_word(input string tag, input logic [3:0] w, input logic exp_ready_last);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s_b%0d", tag, k), {s_x, s_bv, s_done}, {w[3-k], 1'b1, (k == 3)});
      check($sformatf("%s_b%0d_rdy", tag, k), s_ready, (k == 3) ? exp_ready_last : 1'b0);
      check($sformatf("%s_b%0d_busy", tag, k), s_busy, 1'b1);
      if (sel == 0)
        check($sformatf("%s_b%0d_det", tag, k), det_y, (k == 3) && (w == PATTERN_1011));
      if (k < 3) step();
    end
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    sel    = 0;
    rst    = 1'b1;
    data0  = 4'h0;
    data2  = 4'h0;
    valid0 = 1'b0;
    valid2 = 1'b0;

    // 1. reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rst%0d", i), {x0, bv0, ready0, done0, busy0}, 5'b00000);
      check($sformatf("rst%0d_g", i), {x2, bv2, ready2, done2, busy2}, 5'b00000);
    end
    rst = 1'b0;
    step();
    expect_idle("post_rst", 1'b1, 1'b0);

    // 2. single 1011 word, no gap
    data0  = 4'b1011;
    valid0 = 1'b1;
    step();
    valid0 = 1'b0;
    expect_word("w1011", 4'b1011, 1'b1);
    step();
    expect_idle("w1011_end", 1'b1, 1'b0);

    // 3. back-to-back words with valid held
    data0  = 4'b1011;
    valid0 = 1'b1;
    step();
    expect_word("b2b_a", 4'b1011, 1'b1);
    step();
    valid0 = 1'b0;
    expect_word("b2b_b", 4'b1011, 1'b1);
    step();
    expect_idle("b2b_end", 1'b1, 1'b0);

    // 4. two-cycle gap between queued words
    sel    = 1;
    data2  = 4'b1011;
    valid2 = 1'b1;
    step();
    data2 = 4'b0110;
    expect_word("gap_a", 4'b1011, 1'b0);
    step();
    expect_idle("gap_g1", 1'b0, 1'b1);
    step();
    expect_idle("gap_g2", 1'b0, 1'b1);
    step();
    expect_idle("gap_idle", 1'b1, 1'b0);
    step();
    valid2 = 1'b0;
    expect_word("gap_b", 4'b0110, 1'b0);
    step();
    expect_idle("gap_b_g1", 1'b0, 1'b1);
    step();
    step();
    expect_idle("gap_b_end", 1'b1, 1'b0);

    // 5. data_i changed while shifting does not disturb the word in flight
    sel    = 0;
    data0  = 4'b1011;
    valid0 = 1'b1;
    step();
    data0 = 4'b0000;
    expect_word("hold_a", 4'b1011, 1'b1);
    step();
    valid0 = 1'b0;
    expect_word("hold_b", 4'b0000, 1'b1);
    step();
    expect_idle("hold_end", 1'b1, 1'b0);

    // 6. reset in the middle of a word
    data0  = 4'b1011;
    valid0 = 1'b1;
    step();
    valid0 = 1'b0;
    check("mid_b0", {x0, bv0, done0}, 3'b110);
    step();
    check("mid_b1", {x0, bv0, done0}, 3'b010);
    step();
    check("mid_b2", {x0, bv0, done0}, 3'b110);
    rst = 1'b1;
    step();
    check("mid_rst", {x0, bv0, busy0, done0, ready0}, 5'b00000);
    rst = 1'b0;
    step();
    expect_idle("mid_idle", 1'b1, 1'b0);
    data0  = 4'b1101;
    valid0 = 1'b1;
    step();
    valid0 = 1'b0;
    expect_word("mid_new", 4'b1101, 1'b1);
    step();
    expect_idle("mid_new_end", 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_serial_pattern_tx
